// File: rtl/exec_control_unit.sv
// exec_control_unit: single-cycle MIPS-style decoder, ALU, next-PC select and PC register.
// Define EXEC_SHIFT_EN to add R-type sll/srl.
module exec_control_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [31:0] mem_rd,
    output logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic [4:0]  alu_control,
    output logic [31:0] alu_result,
    output logic [31:0] mem_wdata,
    output logic        mem_write_en,
    output logic        reg_write_en,
    output logic [4:0]  reg_write_addr,
    output logic [31:0] reg_write_data,
    output logic        branch_taken
);
    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_NOR = 5'b01100;
    localparam logic [4:0] ALU_SLL = 5'b01000;
    localparam logic [4:0] ALU_SRL = 5'b01001;

    logic [5:0]  op, fn;
    logic [31:0] sign_imm, src_b, pc_plus4;
    logic        alu_src, rd_dst, is_jr, is_jump, is_jal, is_lw, is_blt;

    assign op        = instr[31:26];
    assign fn        = instr[5:0];
    assign sign_imm  = {{16{instr[15]}}, instr[15:0]};
    assign src_b     = alu_src ? sign_imm : rd2;
    assign pc_plus4  = pc + 32'd4;
    assign mem_wdata = rd2;

    always_comb begin
        alu_control  = ALU_ADD;
        alu_src      = 1'b0;
        rd_dst       = 1'b0;
        reg_write_en = 1'b0;
        mem_write_en = 1'b0;
        is_jr        = 1'b0;
        is_jump      = 1'b0;
        is_jal       = 1'b0;
        is_lw        = 1'b0;
        is_blt       = 1'b0;
        case (op)
            6'b000000: begin
                rd_dst = 1'b1;
                case (fn)
                    6'b100000: {alu_control, reg_write_en} = {ALU_ADD, 1'b1};
                    6'b100010: {alu_control, reg_write_en} = {ALU_SUB, 1'b1};
                    6'b100100: {alu_control, reg_write_en} = {ALU_AND, 1'b1};
                    6'b100101: {alu_control, reg_write_en} = {ALU_OR, 1'b1};
                    6'b101010: {alu_control, reg_write_en} = {ALU_SLT, 1'b1};
                    6'b100111: {alu_control, reg_write_en} = {ALU_NOR, 1'b1};
                    6'b001000: is_jr = 1'b1;
`ifdef EXEC_SHIFT_EN
                    6'b000000: {alu_control, reg_write_en} = {ALU_SLL, 1'b1};
                    6'b000010: {alu_control, reg_write_en} = {ALU_SRL, 1'b1};
`endif
                    default: ;
                endcase
            end
            6'b001000: {alu_control, alu_src, reg_write_en} = {ALU_ADD, 2'b11};
            6'b001100: {alu_control, alu_src, reg_write_en} = {ALU_AND, 2'b11};
            6'b001101: {alu_control, alu_src, reg_write_en} = {ALU_OR, 2'b11};
            6'b001010: {alu_control, alu_src, reg_write_en} = {ALU_SLT, 2'b11};
            6'b100011: {alu_src, reg_write_en, is_lw} = 3'b111;
            6'b101011: {alu_src, mem_write_en} = 2'b11;
            6'b000100: {alu_control, is_blt} = {ALU_SUB, 1'b1};
            6'b000010: is_jump = 1'b1;
            6'b000011: {is_jump, is_jal, reg_write_en} = 3'b111;
            default: ;
        endcase
    end

    always_comb begin
        case (alu_control)
            ALU_AND: alu_result = rd1 & src_b;
            ALU_OR:  alu_result = rd1 | src_b;
            ALU_ADD: alu_result = rd1 + src_b;
            ALU_SUB: alu_result = rd1 - src_b;
            ALU_SLT: alu_result = {31'b0, $signed(rd1) < $signed(src_b)};
            ALU_NOR: alu_result = ~(rd1 | src_b);
`ifdef EXEC_SHIFT_EN
            ALU_SLL: alu_result = rd2 << instr[10:6];
            ALU_SRL: alu_result = rd2 >> instr[10:6];
`endif
            default: alu_result = 32'b0;
        endcase
    end

    // blt uses the raw sign of rs-rt, so overflowing differences branch the wrong way by design
    assign branch_taken   = is_blt & alu_result[31];
    assign reg_write_addr = is_jal ? 5'd31 : rd_dst ? instr[15:11] : instr[20:16];
    assign reg_write_data = is_jal ? pc_plus4 : is_lw ? mem_rd : alu_result;
    assign pc_next = is_jr ? rd1 :
                     is_jump ? {pc[31:28], instr[25:0], 2'b00} :
                     branch_taken ? pc_plus4 + {sign_imm[29:0], 2'b00} : pc_plus4;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) pc <= RESET_PC;
        else pc <= pc_next;
    end
endmodule

// File: tb/tb_exec_control_unit.sv
// tb_exec_control_unit: random and directed checks of exec_control_unit against an instruction-level model.
module tb_exec_control_unit;
    logic        clock = 1'b0, reset = 1'b1;
    logic [31:0] instr = 32'b0, rd1 = 32'b0, rd2 = 32'b0, mem_rd = 32'b0;
    logic [31:0] pc, pc_next, alu_result, mem_wdata, reg_write_data;
    logic [4:0]  alu_control, reg_write_addr;
    logic        mem_write_en, reg_write_en, branch_taken;
    int          errors = 0, checks = 0;

    exec_control_unit dut (
        .clock(clock), .reset(reset), .instr(instr), .rd1(rd1), .rd2(rd2), .mem_rd(mem_rd),
        .pc(pc), .pc_next(pc_next), .alu_control(alu_control), .alu_result(alu_result),
        .mem_wdata(mem_wdata), .mem_write_en(mem_write_en), .reg_write_en(reg_write_en),
        .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data), .branch_taken(branch_taken)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc_next, res, wd;
        logic [4:0]  ctl, wa;
        logic        we, mwe, bt, cctl, cres;
    } exp_t;

    function automatic exp_t model(input logic [31:0] i, p, a, b, m);
        exp_t e;
        logic [31:0] imm, p4;
        imm = {{16{i[15]}}, i[15:0]};
        p4 = p + 32'd4;
        e = '0;
        e.pc_next = p4;
        e.ctl = 5'd2;
        e.cctl = 1'b1;
        e.cres = 1'b1;
        e.wa = i[20:16];
        if (i[31:26] == 6'h00) begin
            e.wa = i[15:11];
            case (i[5:0])
                6'h20: begin e.ctl = 5'd2;  e.res = a + b;   e.we = 1'b1; end
                6'h22: begin e.ctl = 5'd6;  e.res = a - b;   e.we = 1'b1; end
                6'h24: begin e.ctl = 5'd0;  e.res = a & b;   e.we = 1'b1; end
                6'h25: begin e.ctl = 5'd1;  e.res = a | b;   e.we = 1'b1; end
                6'h2A: begin e.ctl = 5'd7;  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.we = 1'b1; end
                6'h27: begin e.ctl = 5'd12; e.res = ~(a | b); e.we = 1'b1; end
                6'h08: begin e.pc_next = a; e.cctl = 1'b0; e.cres = 1'b0; end
`ifdef EXEC_SHIFT_EN
                6'h00: begin e.ctl = 5'd8;  e.res = b << i[10:6]; e.we = 1'b1; end
                6'h02: begin e.ctl = 5'd9;  e.res = b >> i[10:6]; e.we = 1'b1; end
`endif
                default: begin e.cctl = 1'b0; e.cres = 1'b0; end
            endcase
        end else begin
            case (i[31:26])
                6'h08: begin e.res = a + imm; e.we = 1'b1; end
                6'h0C: begin e.ctl = 5'd0; e.res = a & imm; e.we = 1'b1; end
                6'h0D: begin e.ctl = 5'd1; e.res = a | imm; e.we = 1'b1; end
                6'h0A: begin e.ctl = 5'd7; e.res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0; e.we = 1'b1; end
                6'h23: begin e.res = a + imm; e.we = 1'b1; end
                6'h2B: begin e.res = a + imm; e.mwe = 1'b1; end
                6'h04: begin
                    e.ctl = 5'd6;
                    e.res = a - b;
                    e.bt = e.res[31];
                    if (e.bt) e.pc_next = p4 + imm * 4;
                end
                6'h02: begin e.pc_next = {p[31:28], i[25:0], 2'b00}; e.cctl = 1'b0; e.cres = 1'b0; end
                6'h03: begin
                    e.pc_next = {p[31:28], i[25:0], 2'b00};
                    e.cctl = 1'b0; e.cres = 1'b0; e.we = 1'b1; e.wa = 5'd31;
                end
                default: e.cres = 1'b0;
            endcase
        end
        e.wd = (i[31:26] == 6'h23) ? m : (i[31:26] == 6'h03) ? p4 : e.res;
        return e;
    endfunction

    logic [31:0] mpc;
    exp_t cur;
    always_comb cur = model(instr, mpc, rd1, rd2, mem_rd);

    always @(posedge clock or posedge reset) begin
        if (reset) mpc <= 32'h0;
        else mpc <= cur.pc_next;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (instr=%h pc=%h)", name, act, exp, instr, pc);
        end
    endtask

    always @(negedge clock) begin
        chk("pc", pc, mpc);
        chk("pc_next", pc_next, cur.pc_next);
        chk("mem_wdata", mem_wdata, rd2);
        chk("mem_write_en", {31'b0, mem_write_en}, {31'b0, cur.mwe});
        chk("reg_write_en", {31'b0, reg_write_en}, {31'b0, cur.we});
        chk("branch_taken", {31'b0, branch_taken}, {31'b0, cur.bt});
        if (cur.cctl) chk("alu_control", {27'b0, alu_control}, {27'b0, cur.ctl});
        if (cur.cres) chk("alu_result", alu_result, cur.res);
        if (cur.we) begin
            chk("reg_write_addr", {27'b0, reg_write_addr}, {27'b0, cur.wa});
            chk("reg_write_data", reg_write_data, cur.wd);
        end
    end

    localparam logic [5:0] OPS [11] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h3F};
    localparam logic [5:0] FNS [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h08, 6'h00, 6'h02, 6'h11};

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom();
        k = $urandom_range(0, 14);
        if (k == 11) return r;
        if (k > 11) k = 0;
        r[31:26] = OPS[k];
        if (k == 0) r[5:0] = FNS[$urandom_range(0, 9)];
        return r;
    endfunction

    function automatic logic [31:0] rand_data();
        return ($urandom_range(0, 2) == 0) ? ($urandom_range(0, 8) - 32'd4) : $urandom();
    endfunction

    task automatic drive(input logic [31:0] i, a, b, m);
        instr = i; rd1 = a; rd2 = b; mem_rd = m;
        #1;
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("reset_pc", pc, 32'h0);
        reset = 1'b0;
        repeat (20) begin
            next();
            drive(rand_instr(), rand_data(), rand_data(), $urandom());
        end
        next();
        drive(32'h0, $urandom(), $urandom(), $urandom());
        reset = 1'b1;
        #1 chk("reset_async_pc", pc, 32'h0);
        reset = 1'b0;
        next();
        chk("pc_after_reset", pc, 32'h4);
        drive(32'h00221820, 32'd7, 32'hFFFF_FFFE, 32'h0);
        chk("add_result", alu_result, 32'd5);
        chk("add_waddr", {27'b0, reg_write_addr}, 32'd3);
        chk("add_we", {31'b0, reg_write_en}, 32'd1);
        chk("add_pc_next", pc_next, 32'h8);
        next();
        drive(32'h8C22FFFC, 32'd16, 32'h0, 32'hABCD);
        chk("lw_addr", alu_result, 32'd12);
        chk("lw_wdata", reg_write_data, 32'hABCD);
        drive(32'hAC22FFFC, 32'd16, 32'h0, 32'hABCD);
        chk("sw_mwe", {31'b0, mem_write_en}, 32'd1);
        chk("sw_we", {31'b0, reg_write_en}, 32'd0);
        next();
        drive(32'h00200008, 32'h100, 32'h0, 32'h0);
        next();
        chk("pc_at_blt", pc, 32'h100);
        drive(32'h10220003, 32'd2, 32'd5, 32'h0);
        chk("blt_taken", {31'b0, branch_taken}, 32'd1);
        chk("blt_target", pc_next, 32'h110);
        drive(32'h10220003, 32'd5, 32'd2, 32'h0);
        chk("blt_not_taken", pc_next, 32'h104);
        next();
        drive(32'h00200008, 32'h1000_0008, 32'h0, 32'h0);
        next();
        chk("pc_at_jal", pc, 32'h1000_0008);
        drive(32'h0C000040, 32'h0, 32'h0, 32'h0);
        chk("jal_pc_next", pc_next, 32'h1000_0100);
        chk("jal_waddr", {27'b0, reg_write_addr}, 32'd31);
        chk("jal_wdata", reg_write_data, 32'h1000_000C);
        next();
        drive(32'h03E00008, 32'h24, 32'h0, 32'h0);
        chk("jr_pc_next", pc_next, 32'h24);
        chk("jr_we", {31'b0, reg_write_en}, 32'd0);
        drive(32'h0022182A, 32'hFFFF_FFFF, 32'd1, 32'h0);
        chk("slt_result", alu_result, 32'd1);
        repeat (1500) begin
            next();
            drive(rand_instr(), rand_data(), rand_data(), $urandom());
        end
        next();
        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exec_control_unit.md
Name: exec_control_unit

Overview:
- Single-cycle MIPS-style decode/execute core: instruction decoder (control), 32-bit ALU, PC+4 and branch-target adders, next-PC select and the program counter register.
- Sits between instruction memory, the register file and data memory.
- All outputs except `pc` are combinational from `instr`, `pc`, `rd1`, `rd2` and `mem_rd`.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into `pc` on reset.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces `pc` to RESET_PC
- instr  in  32  current instruction (imem data at `pc`)
- rd1  in  32  register file read data for rs (instr[25:21])
- rd2  in  32  register file read data for rt (instr[20:16])
- mem_rd  in  32  data memory read data
- pc  out  32  registered program counter
- pc_next  out  32  selected next PC
- alu_control  out  5  ALU operation code
- alu_result  out  32  ALU output; also the data memory address
- mem_wdata  out  32  equals rd2
- mem_write_en  out  1  store enable
- reg_write_en  out  1  register file write enable
- reg_write_addr  out  5  destination register
- reg_write_data  out  32  register writeback value
- branch_taken  out  1  branch instruction AND alu_result[31]

Behaviour:
- Reset and PC update:
  - While `reset` is high, `pc` = RESET_PC, independent of the clock.
  - Otherwise `pc` <= `pc_next` on each rising edge. No stall.
- Immediate: SignImm = sign-extend(instr[15:0]). All I-type ops use SignImm, including andi and ori.
- ALU codes:
  - AND 00000, OR 00001, ADD 00010, SUB 00110, SLT 00111, NOR 01100.
  - SLT is a signed compare giving 1 or 0.
  - Add and subtract wrap mod 2^32.
  - Undefined codes produce 0.
- ALU operands: SrcA = `rd1`. SrcB = SignImm when ALUSrc, else `rd2`.
- Decode, R-type (opcode 000000), by funct:
  - add 100000, sub 100010, and 100100, or 100101, slt 101010, nor 100111.
  - These write rd (instr[15:11]) with `alu_result`.
  - jr 001000: no register write; `pc_next` = `rd1`.
  - Unknown funct: nop, no writes.
- Decode, I-type and J-type (all writes go to rt unless noted):
  - addi 001000: ADD, writes rt.
  - andi 001100: AND, writes rt.
  - ori 001101: OR, writes rt.
  - slti 001010: SLT, writes rt.
  - lw 100011: ADD; writes rt with `mem_rd`.
  - sw 101011: ADD; `mem_write_en` = 1; no register write.
  - blt 000100: SUB on rs-rt.
    - Taken when `alu_result[31]` = 1. This is the raw sign bit, with no overflow correction.
    - No register write.
  - j 000010: jump, no register write.
  - jal 000011: jump; writes register 31 with `pc` + 4.
  - Unknown opcode: nop (both write enables 0, `pc_next` = `pc` + 4, `alu_control` = ADD).
- Writeback select: jal → `pc` + 4; lw → `mem_rd`; otherwise → `alu_result`.
- Next PC, in priority order:
  1. jr → `rd1`.
  2. j or jal → {pc[31:28], instr[25:0], 2'b00}.
  3. blt taken → (`pc` + 4) + (SignImm << 2).
  4. Otherwise → `pc` + 4.
- All adders are 32-bit and wrap; a carry out is discarded.

Optional Feature:
- Macro EXEC_SHIFT_EN.
- Defined:
  - R-type sll (funct 000000) and srl (funct 000010) shift `rd2` by instr[10:6].
  - ALU codes are 01000 (sll) and 01001 (srl). Result written to rd.
  - `instr` = 0 therefore writes register 0 with 0.
- Not defined: those functs are unknown-funct nops, and the codes 01000/01001 produce 0.

Test Plan:
- Reset mid-run: assert `reset` between edges → `pc` = 0 immediately. Release, then one edge with `instr` = 0 → `pc` = 4.
- add $3,$1,$2 (32'h00221820) with `rd1` = 7, `rd2` = 32'hFFFFFFFE → `alu_result` = 5, `reg_write_addr` = 3, `reg_write_en` = 1, `pc_next` = `pc` + 4.
- lw $2,-4($1) (32'h8C22FFFC) with `rd1` = 16, `mem_rd` = 32'hABCD → `alu_result` = 12, `reg_write_data` = 32'hABCD. Then sw with the same fields → `mem_write_en` = 1, `reg_write_en` = 0.
- blt at `pc` = 32'h100, offset 3:
  - `rd1` = 2, `rd2` = 5 → `branch_taken` = 1, `pc_next` = 32'h110.
  - `rd1` = 5, `rd2` = 2 → `pc_next` = 32'h104.
- jal 0x40 at `pc` = 32'h1000_0008 → `pc_next` = 32'h1000_0100, `reg_write_addr` = 31, `reg_write_data` = 32'h1000_000C.
- jr $31 with `rd1` = 32'h24 → `pc_next` = 32'h24, `reg_write_en` = 0. slt with `rd1` = -1, `rd2` = 1 → `alu_result` = 1.
